bcd_counter_chain: RTL

//  Parametrised multi-digit modulo-N up/down counter with synchronous load and clear.

---
 rtl/fsd_counter_pkg.sv | 30 +++
 rtl/bcd_digit_cell.sv | 40 ++++
 rtl/bcd_counter_chain.sv | 60 ++++++
 3 files changed

// File: rtl/fsd_counter_pkg.sv
// Shared digit helpers for the cascaded modulo-N counter.
package fsd_counter_pkg;

    localparam int DW = 4;

    // Loaded digits outside 0..modulus-1 saturate to the top digit value.
    function automatic logic [DW-1:0] clamp_digit(input logic [DW-1:0] val,
                                                  input int           modulus);
        logic [DW-1:0] top;
        top = DW'(modulus - 1);
        return (val >= top) ? top : val;
    endfunction

    // One step of a single digit. Explicit compares against modulus-1 keep
    // non-power-of-two moduli from relying on 4-bit overflow; an out-of-range
    // digit behaves as if it were modulus-1.
    function automatic logic [DW-1:0] digit_next(input logic [DW-1:0] d,
                                                 input logic          up,
                                                 input int            modulus);
        logic [DW-1:0] top;
        logic [DW-1:0] dc;
        top = DW'(modulus - 1);
        dc  = clamp_digit(d, modulus);
        if (up)
            return (dc == top) ? '0 : dc + DW'(1);
        else
            return (dc == '0) ? top : dc - DW'(1);
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One counter digit: holds its value and forwards the ripple step to the
// next more-significant digit.
module bcd_digit_cell
    import fsd_counter_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] load_d,
    input  logic          step_in,
    input  logic          up,
    output logic [DW-1:0] d,
    output logic          at_max,
    output logic          at_zero,
    output logic          step_out
);

    localparam logic [DW-1:0] TOP = DW'(MODULUS - 1);

    // Out-of-range values count as the top digit so carries stay sane.
    assign at_max   = (d >= TOP);
    assign at_zero  = (d == '0);
    assign step_out = step_in & (up ? at_max : at_zero);

    // Digit register: clear beats load beats step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            d <= '0;
        else if (clear)
            d <= '0;
        else if (load)
            d <= clamp_digit(load_d, MODULUS);
        else if (step_in)
            d <= digit_next(d, up, MODULUS);
    end

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit modulo-N up/down counter with load, clear, terminal count and a
// registered wrap pulse. q drives the 7-segment decoders.
module bcd_counter_chain
    import fsd_counter_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int MODULUS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic [4*DIGITS-1:0]  load_val,
    input  logic                 en,
    input  logic                 up,
    output logic [4*DIGITS-1:0]  q,
    output logic                 tc,
    output logic                 wrap
);

    logic [DIGITS:0]   step;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_zero;

    assign step[0] = en;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            bcd_digit_cell #(
                .MODULUS (MODULUS)
            ) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear    (clear),
                .load     (load),
                .load_d   (load_val[DW*k +: DW]),
                .step_in  (step[k]),
                .up       (up),
                .d        (q[DW*k +: DW]),
                .at_max   (at_max[k]),
                .at_zero  (at_zero[k]),
                .step_out (step[k+1])
            );
        end
    endgenerate

    assign tc = en & (up ? (&at_max) : (&at_zero));

    // The carry out of the top digit is exactly a full wrap on this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wrap <= 1'b0;
        else if (clear || load)
            wrap <= 1'b0;
        else
            wrap <= step[DIGITS];
    end

endmodule
